// File: rtl/vec_pair_loader.sv
// vec_pair_loader: serial-to-parallel front end for the dot-product datapath.
// Collects N_ELEM (a,b) element pairs into one of two banks and presents the
// oldest completed bank on a valid/ready output. Ingest into the other bank
// continues while a completed vector pair waits for the consumer.
// Optional build macro VEC_PAIR_LOADER_ZERO_PAD_EN: in_last closes a short
// vector early and zero-fills its remaining slots. When undefined, in_last is
// ignored.
module vec_pair_loader #(
    parameter int N_ELEM = 8,
    parameter int ELEM_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_a,
    input  logic [ELEM_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] vector_a [N_ELEM-1:0],
    output logic [ELEM_W-1:0] vector_b [N_ELEM-1:0],
    output logic [CNT_W-1:0]  vec_count
);

    localparam int IDX_W = $clog2(N_ELEM);

    logic [1:0][N_ELEM-1:0][ELEM_W-1:0] bank_a;
    logic [1:0][N_ELEM-1:0][ELEM_W-1:0] bank_b;
    logic [1:0]       full;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [IDX_W-1:0] idx;
    logic             in_fire;
    logic             out_fire;
    logic             done;

    // Both sides are decided from registered state only; out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = !full[wr_ptr];
    assign out_valid = full[rd_ptr];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef VEC_PAIR_LOADER_ZERO_PAD_EN
    assign done = (idx == IDX_W'(N_ELEM - 1)) || in_last;
`else
    assign done = (idx == IDX_W'(N_ELEM - 1));
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Presented bank drives the vector outputs continuously.
    for (genvar e = 0; e < N_ELEM; e++) begin : g_out
        assign vector_a[e] = bank_a[rd_ptr][e];
        assign vector_b[e] = bank_b[rd_ptr][e];
    end

    // Element storage: write the accepted pair into the slot being filled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_a <= '0;
            bank_b <= '0;
        end else if (in_fire) begin
            bank_a[wr_ptr][idx] <= in_a;
            bank_b[wr_ptr][idx] <= in_b;
`ifdef VEC_PAIR_LOADER_ZERO_PAD_EN
            // Short vector: clear the tail so stale data from an earlier
            // fill cannot leak into the dot product.
            if (in_last) begin
                for (int i = 0; i < N_ELEM; i++) begin
                    if (i > int'(idx)) begin
                        bank_a[wr_ptr][i] <= '0;
                        bank_b[wr_ptr][i] <= '0;
                    end
                end
            end
`endif
        end
    end

    // Bank bookkeeping: fill/drain pointers, full flags and handoff counter.
    // A filling bank is never full and a presented bank always is, so the
    // set and clear of full[] in one cycle always target different banks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= '0;
            vec_count <= '0;
        end else begin
            if (in_fire) begin
                if (done) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                    idx          <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (out_fire) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
                vec_count    <= vec_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_pair_loader.sv
// Bench for vec_pair_loader: table-driven directed vectors, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_vec_pair_loader;

    localparam int N = 8;
    localparam int W = 8;
    localparam int C = 16;
`ifdef VEC_PAIR_LOADER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid;
    logic [W-1:0] vector_a [N-1:0];
    logic [W-1:0] vector_b [N-1:0];
    logic [C-1:0] vec_count;

    // Narrow-counter instance to reach the wrap point in few handoffs.
    logic s_in_ready, s_out_valid;
    logic [W-1:0] s_va [N-1:0];
    logic [W-1:0] s_vb [N-1:0];
    logic [2:0] s_count;

    vec_pair_loader #(.N_ELEM(N), .ELEM_W(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .vector_a(vector_a), .vector_b(vector_b),
        .vec_count(vec_count));

    vec_pair_loader #(.N_ELEM(N), .ELEM_W(W), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .vector_a(s_va), .vector_b(s_vb),
        .vec_count(s_count));

    always #5 clk = ~clk;

    logic [N-1:0][W-1:0] va_p, vb_p;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign va_p[g] = vector_a[g];
        assign vb_p[g] = vector_b[g];
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference model: completed vectors wait in a queue (at most two fit),
    // the partial vector is a plain list of accepted elements.
    typedef struct packed {
        logic [N-1:0][W-1:0] a;
        logic [N-1:0][W-1:0] b;
    } vec_t;
    vec_t pend[$];
    logic [W-1:0] pa[$];
    logic [W-1:0] pb[$];
    logic [C-1:0] mcount;

    task automatic model_clear();
        pend.delete(); pa.delete(); pb.delete(); mcount = '0;
    endtask

    task automatic model_edge(input bit inf, input bit outf, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit last);
        vec_t v;
        if (outf) begin
            void'(pend.pop_front());
            mcount = mcount + 1'b1;
        end
        if (inf) begin
            pa.push_back(a); pb.push_back(b);
            if (pa.size() == N || (ZP && last)) begin
                v = '0;
                for (int i = 0; i < pa.size(); i++) begin
                    v.a[i] = pa[i]; v.b[i] = pb[i];
                end
                pend.push_back(v);
                pa.delete(); pb.delete();
            end
        end
    endtask

    task automatic model_check();
        chk("in_ready", in_ready, pend.size() < 2);
        chk("out_valid", out_valid, pend.size() > 0);
        chk("vec_count", vec_count, mcount);
        if (pend.size() > 0) begin
            chk("vector_a", va_p, pend[0].a);
            chk("vector_b", vb_p, pend[0].b);
        end
    endtask

    // One clock: inputs are already stable; model follows the edge, outputs
    // are compared at the following falling edge.
    task automatic step(output bit inf);
        bit outf;
        inf  = in_valid && (pend.size() < 2);
        outf = (pend.size() > 0) && out_ready;
        @(posedge clk);
        model_edge(inf, outf, in_a, in_b, in_last);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
        bit f;
        int guard;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        guard = 0;
        do begin
            step(f);
            guard++;
        end while (!f && guard < 50);
        if (!f) chk("feed_timeout", 1, 0);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    typedef struct {
        bit           iv;
        logic [W-1:0] a, b;
        bit           exp_ov;
        bit           exp_ir;
        logic [C-1:0] exp_cnt;
    } row_t;
    row_t tbl [N+1];

    initial begin
        bit f;
        int k, pulses, drops;
        logic [W-1:0] firsts[$];
        logic [N-1:0][W-1:0] ea, eb;

        for (int i = 0; i < N; i++) tbl[i] = '{1'b1, W'(i + 1), W'(i + 2), (i == N - 1), 1'b1, C'(0)};
        tbl[N] = '{1'b0, W'(0), W'(0), 1'b0, 1'b1, C'(1)};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_vec_count", vec_count, 0);
        chk("rst_vector_a", va_p, 0);
        chk("rst_vector_b", vb_p, 0);
        reset = 1'b0;
        model_clear();

        // 1: one vector, consumer always ready (table driven)
        out_ready = 1'b1;
        for (int r = 0; r <= N; r++) begin
            in_valid = tbl[r].iv; in_a = tbl[r].a; in_b = tbl[r].b;
            step(f);
            chk("t1_out_valid", out_valid, tbl[r].exp_ov);
            chk("t1_in_ready", in_ready, tbl[r].exp_ir);
            chk("t1_vec_count", vec_count, tbl[r].exp_cnt);
            if (r == N - 1) begin
                for (int i = 0; i < N; i++) begin
                    chk("t1_elem_a", vector_a[i], i + 1);
                    chk("t1_elem_b", vector_b[i], i + 2);
                end
            end
        end
        in_valid = 1'b0;

        // 2: backpressure, 24 pairs, release later
        do_reset();
        k = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            out_ready = (cyc >= 30);
            in_valid = (k < 24); in_a = W'(k + 1); in_b = W'(k + 101);
            if (out_valid && out_ready) firsts.push_back(vector_a[0]);
            step(f);
            if (f) k++;
            if (cyc == 20) begin
                chk("t2_hs_at_stall", k, 16);
                chk("t2_in_ready_low", in_ready, 0);
                chk("t2_held_valid", out_valid, 1);
                chk("t2_held_vec", vector_a[0], 1);
            end
        end
        in_valid = 1'b0;
        chk("t2_accepted", k, 24);
        chk("t2_vec_count", vec_count, 3);
        chk("t2_n_out", firsts.size(), 3);
        if (firsts.size() == 3) begin
            chk("t2_order0", firsts[0], 1);
            chk("t2_order1", firsts[1], 9);
            chk("t2_order2", firsts[2], 17);
        end

        // 3: sustained throughput, plus narrow counter wrap
        do_reset();
        out_ready = 1'b1;
        pulses = 0; drops = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            step(f);
            if (out_valid) pulses++;
            if (!in_ready) drops++;
        end
        chk("t3_small_cnt7", s_count, 7);
        in_valid = 1'b0;
        step(f);
        if (out_valid) pulses++;
        chk("t3_pulses", pulses, 8);
        chk("t3_in_ready_drops", drops, 0);
        chk("t3_vec_count", vec_count, 8);
        chk("t3_small_wrap", s_count, 0);

        // 4: asynchronous reset mid-fill
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N + 5; i++) feed(W'(i + 1), W'(i + 50), 1'b0);
        chk("t4_pre_count", vec_count, 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_vec_count", vec_count, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_vector_a", va_p, 0);
        chk("t4_vector_b", vb_p, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) feed(W'(i + 30), W'(i + 70), 1'b0);
        for (int i = 0; i < N; i++) ea[i] = W'(i + 30);
        chk("t4_new_vec", va_p, ea);

        // 5: short vector with in_last into a bank holding stale data
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) feed(8'hAA, 8'hAA, 1'b0);
        in_valid = 1'b0;
        step(f);
        out_ready = 1'b0;
        feed(5, 5, 1'b0); feed(6, 6, 1'b0); feed(7, 7, 1'b1);
        if (ZP) begin
            for (int i = 0; i < N; i++) ea[i] = (i < 3) ? W'(5 + i) : W'(0);
            chk("t5_zp_valid", out_valid, 1);
            chk("t5_zp_a", va_p, ea);
            chk("t5_zp_b", vb_p, ea);
        end else begin
            chk("t5_no_early_valid", out_valid, 0);
            for (int i = 3; i < N; i++) feed(W'(5 + i), W'(5 + i), 1'b0);
            for (int i = 0; i < N; i++) begin
                ea[i] = W'(5 + i); eb[i] = W'(5 + i);
            end
            chk("t5_valid", out_valid, 1);
            chk("t5_a", va_p, ea);
            chk("t5_b", vb_p, eb);
        end

        // Randomized run against the model
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (cyc % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 9) == 0);
            in_a = W'($urandom); in_b = W'($urandom);
            step(f);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
